// File: rtl/scene_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scene_pkg
// Purpose  : Shared scene codes, default frame constants and a small helper
//            for the scene sequencer and its sub-blocks.
// Contents : S_START..S_LOSE       3-bit scene codes (7 is never produced)
//            c_TWINKLE_FRAMES      default frames per twinkle half-period
//            c_GUARD_FRAMES        default frames before a tap is accepted
//            is_banner()           true for START/WIN/LOSE (text scenes)
// Revision : 1.0 - initial release
// ============================================================================
package scene_pkg;

    localparam logic [2:0] S_START = 3'd0;
    localparam logic [2:0] S_MENU  = 3'd1;
    localparam logic [2:0] S_PLAY1 = 3'd2;
    localparam logic [2:0] S_PLAY2 = 3'd3;
    localparam logic [2:0] S_PLAY3 = 3'd4;
    localparam logic [2:0] S_WIN   = 3'd5;
    localparam logic [2:0] S_LOSE  = 3'd6;

    localparam int c_TWINKLE_FRAMES = 30;
    localparam int c_GUARD_FRAMES   = 20;

    // Scenes that show blinking "Tap To Continue" text.
    function automatic logic is_banner(input logic [2:0] s);
        return (s == S_START) || (s == S_WIN) || (s == S_LOSE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/twinkle_gen.sv
`default_nettype none
// ============================================================================
// Module   : twinkle_gen
// Purpose  : Frame-tick divider producing the blink strobe for banner text.
//            twinkle toggles every TWINKLE_FRAMES frame ticks.
// Ports    : clk         in   system clock
//            rst         in   synchronous active-low reset (twinkle -> 1)
//            frame_tick  in   one-cycle pulse per frame
//            restart     in   entering a banner scene: twinkle=1, count=0
//            hold        in   next scene is not a banner: twinkle=0, count=0
//            twinkle     out  blink strobe (registered)
// Revision : 1.0 - initial release
// ============================================================================
module twinkle_gen #(
    parameter int TWINKLE_FRAMES = 30,
    parameter int FCNT_W         = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_tick,
    input  logic restart,
    input  logic hold,
    output logic twinkle
);

    localparam logic [FCNT_W-1:0] c_LAST = FCNT_W'(TWINKLE_FRAMES - 1);

    logic [FCNT_W-1:0] r_tw_cnt;
    logic              r_twinkle;

    // restart/hold take priority over frame_tick so a tick landing in the
    // same cycle as a scene change is swallowed by the clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tw_cnt  <= '0;
            r_twinkle <= 1'b1;
        end else if (hold) begin
            r_tw_cnt  <= '0;
            r_twinkle <= 1'b0;
        end else if (restart) begin
            r_tw_cnt  <= '0;
            r_twinkle <= 1'b1;
        end else if (frame_tick) begin
            if (r_tw_cnt == c_LAST) begin
                r_tw_cnt  <= '0;
                r_twinkle <= ~r_twinkle;
            end else begin
                r_tw_cnt  <= r_tw_cnt + 1'b1;
            end
        end
    end

    assign twinkle = r_twinkle;

endmodule
`default_nettype wire

// File: rtl/scene_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scene_ctrl
// Purpose  : Top-level scene sequencer. Owns the 3-bit scene register and the
//            twinkle strobe; reacts to taps, menu level selection and game
//            win/lose events, with a tap guard after entering text scenes.
// Ports    : clk              in   system clock, posedge
//            rst              in   synchronous active-low reset
//            frame_tick       in   one-cycle pulse per VGA frame
//            tap              in   mouse left-button level (synchronous)
//            level_sel_valid  in   one-cycle menu selection pulse
//            level_sel[1:0]   in   0/1/2 = PLAY1/2/3, 3 = invalid
//            win_evt          in   one-cycle win pulse
//            lose_evt         in   one-cycle lose pulse
//            scene[2:0]       out  current scene code
//            twinkle          out  blink strobe for START/WIN/LOSE text
//            scene_enter      out  pulse in the first cycle of a new scene
// Options  : AUTO_RETURN_EN - when defined, WIN/LOSE return to MENU on their
//            own after AUTO_FRAMES frame ticks.
// Revision : 1.0 - initial release
// ============================================================================
module scene_ctrl
    import scene_pkg::*;
#(
    parameter int TWINKLE_FRAMES = c_TWINKLE_FRAMES,
    parameter int GUARD_FRAMES   = c_GUARD_FRAMES,
    parameter int AUTO_FRAMES    = 600,
    parameter int FCNT_W         = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       tap,
    input  logic       level_sel_valid,
    input  logic [1:0] level_sel,
    input  logic       win_evt,
    input  logic       lose_evt,
    output logic [2:0] scene,
    output logic       twinkle,
    output logic       scene_enter
);

    localparam logic [FCNT_W-1:0] c_GUARD = FCNT_W'(GUARD_FRAMES);

    logic [2:0]        r_scene;
    logic              r_scene_enter;
    logic              r_tap_d;
    logic [FCNT_W-1:0] r_guard_cnt;

    logic [2:0]        w_next;
    logic              w_change;
    logic              w_tap_rise;
    logic              w_guard_ok;
    logic              w_in_result;
    logic              w_auto_to;

    assign w_tap_rise  = tap & ~r_tap_d;
    assign w_guard_ok  = (r_guard_cnt == c_GUARD);
    assign w_in_result = (r_scene == S_WIN) || (r_scene == S_LOSE);

`ifdef AUTO_RETURN_EN
    localparam logic [FCNT_W-1:0] c_AUTO = FCNT_W'(AUTO_FRAMES);

    logic [FCNT_W-1:0] r_auto_cnt;

    // Only advances in WIN/LOSE; every scene change lands it back at zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_auto_cnt <= '0;
        end else if (w_change) begin
            r_auto_cnt <= '0;
        end else if (w_in_result && frame_tick && (r_auto_cnt != c_AUTO)) begin
            r_auto_cnt <= r_auto_cnt + 1'b1;
        end
    end

    assign w_auto_to = w_in_result && (r_auto_cnt == c_AUTO);
`else
    assign w_auto_to = 1'b0;
`endif

    // Next-scene decode. Events not meaningful in the current scene fall
    // through and are simply lost.
    always_comb begin
        w_next = r_scene;
        case (r_scene)
            S_START: begin
                if (w_tap_rise && w_guard_ok) w_next = S_MENU;
            end
            S_MENU: begin
                if (level_sel_valid && (level_sel != 2'd3))
                    w_next = S_PLAY1 + {1'b0, level_sel};
            end
            S_PLAY1, S_PLAY2, S_PLAY3: begin
                if (lose_evt)     w_next = S_LOSE;
                else if (win_evt) w_next = S_WIN;
            end
            S_WIN, S_LOSE: begin
                // Tap and timeout together still yield a single transition.
                if ((w_tap_rise && w_guard_ok) || w_auto_to) w_next = S_MENU;
            end
            default: w_next = S_START;
        endcase
    end

    assign w_change = (w_next != r_scene);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_scene       <= S_START;
            r_scene_enter <= 1'b0;
            r_tap_d       <= 1'b0;
            r_guard_cnt   <= '0;
        end else begin
            r_scene       <= w_next;
            r_scene_enter <= w_change;
            r_tap_d       <= tap;
            if (w_change) begin
                r_guard_cnt <= '0;
            end else if (frame_tick && !w_guard_ok) begin
                r_guard_cnt <= r_guard_cnt + 1'b1;
            end
        end
    end

    // Control is derived from the scene being entered so the strobe is
    // already correct in the first cycle the new scene is visible.
    twinkle_gen #(
        .TWINKLE_FRAMES (TWINKLE_FRAMES),
        .FCNT_W         (FCNT_W)
    ) u_twinkle_gen (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .restart    (w_change && is_banner(w_next)),
        .hold       (!is_banner(w_next)),
        .twinkle    (twinkle)
    );

    assign scene       = r_scene;
    assign scene_enter = r_scene_enter;

endmodule
`default_nettype wire

// File: tb/tb_scene_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scene_ctrl
// Purpose  : Self-checking bench for scene_ctrl. A reference model tracks the
//            scene and the number of frame ticks since the scene was entered;
//            guard, twinkle phase and auto-return are derived from that count.
// Options  : AUTO_RETURN_EN - expectations follow the same define as the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scene_ctrl;

`ifdef AUTO_RETURN_EN
    localparam bit c_AUTO = 1'b1;
`else
    localparam bit c_AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0;
    logic       tap = 1'b0;
    logic       level_sel_valid = 1'b0;
    logic [1:0] level_sel = 2'd0;
    logic       win_evt = 1'b0;
    logic       lose_evt = 1'b0;
    logic [2:0] scene;
    logic       twinkle;
    logic       scene_enter;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_scene  = 0;
    int m_frames = 0;
    bit m_enter  = 1'b0;
    bit m_tap_d  = 1'b0;

    scene_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .frame_tick      (frame_tick),
        .tap             (tap),
        .level_sel_valid (level_sel_valid),
        .level_sel       (level_sel),
        .win_evt         (win_evt),
        .lose_evt        (lose_evt),
        .scene           (scene),
        .twinkle         (twinkle),
        .scene_enter     (scene_enter)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Scene rules applied to the inputs present at a clock edge.
    task automatic model_update();
        bit rise, ok;
        int nxt;
        if (!rst) begin
            m_scene = 0; m_frames = 0; m_enter = 1'b0; m_tap_d = 1'b0;
        end else begin
            rise = tap && !m_tap_d;
            ok   = (m_frames >= 20);
            nxt  = m_scene;
            if (m_scene == 0) begin
                if (rise && ok) nxt = 1;
            end else if (m_scene == 1) begin
                if (level_sel_valid && level_sel != 2'd3) nxt = 2 + int'(level_sel);
            end else if (m_scene >= 2 && m_scene <= 4) begin
                if (lose_evt) nxt = 6;
                else if (win_evt) nxt = 5;
            end else if (m_scene == 5 || m_scene == 6) begin
                if ((rise && ok) || (c_AUTO && m_frames >= 600)) nxt = 1;
            end else begin
                nxt = 0;
            end
            m_enter = (nxt != m_scene);
            if (m_enter) m_frames = 0;
            else if (frame_tick) m_frames++;
            m_scene = nxt;
            m_tap_d = tap;
        end
    endtask

    function automatic bit exp_twinkle();
        if (m_scene == 0 || m_scene == 5 || m_scene == 6)
            return ((m_frames / 30) % 2) == 0;
        return 1'b0;
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("model_scene",   32'(scene),       32'(m_scene));
        chk("model_twinkle", 32'(twinkle),     32'(exp_twinkle()));
        chk("model_enter",   32'(scene_enter), 32'(m_enter));
    endtask

    task automatic cycles(input int n);
        repeat (n) step();
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_tick = 1'b1; step();
            frame_tick = 1'b0; step();
        end
    endtask

    task automatic pulse_tap();
        tap = 1'b1; step();
        tap = 1'b0; step();
    endtask

    task automatic select_level(input logic [1:0] lv);
        level_sel = lv; level_sel_valid = 1'b1; step();
        level_sel_valid = 1'b0; step();
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        cycles(3);
        chk("reset_scene", 32'(scene), 32'd0);
        chk("reset_twinkle", 32'(twinkle), 32'd1);
        chk("reset_enter", 32'(scene_enter), 32'd0);
        rst = 1'b1;

        // Tap before guard is discarded
        pulse_tap();
        chk("early_tap", 32'(scene), 32'd0);
        frames(20);
        tap = 1'b1; step();
        chk("start_to_menu", 32'(scene), 32'd1);
        chk("enter_pulse", 32'(scene_enter), 32'd1);
        tap = 1'b0; step();
        chk("enter_one_cycle", 32'(scene_enter), 32'd0);
        chk("menu_twinkle", 32'(twinkle), 32'd0);

        // MENU: invalid level, stray events ignored
        level_sel = 2'd3; level_sel_valid = 1'b1; step();
        chk("lvl3_scene", 32'(scene), 32'd1);
        chk("lvl3_enter", 32'(scene_enter), 32'd0);
        level_sel_valid = 1'b0;
        win_evt = 1'b1; step(); win_evt = 1'b0;
        pulse_tap();
        chk("menu_drops", 32'(scene), 32'd1);
        select_level(2'd2);
        chk("menu_to_play3", 32'(scene), 32'd4);

        // PLAY3: selection ignored; win+lose together -> LOSE
        select_level(2'd0);
        chk("play_ignores_sel", 32'(scene), 32'd4);
        win_evt = 1'b1; lose_evt = 1'b1; step();
        win_evt = 1'b0; lose_evt = 1'b0;
        chk("lose_wins_tie", 32'(scene), 32'd6);
        cycles(3);
        win_evt = 1'b1; step(); win_evt = 1'b0;
        chk("win_in_lose", 32'(scene), 32'd6);

        // LOSE guard then exit
        frames(5);
        pulse_tap();
        chk("lose_guard", 32'(scene), 32'd6);
        frames(20);
        pulse_tap();
        chk("lose_to_menu", 32'(scene), 32'd1);

        // WIN with tap held throughout; twinkle pattern over 100 frames
        select_level(2'd0);
        chk("menu_to_play1", 32'(scene), 32'd2);
        tap = 1'b1; step();
        win_evt = 1'b1; step(); win_evt = 1'b0;
        chk("play_to_win", 32'(scene), 32'd5);
        chk("win_twinkle_entry", 32'(twinkle), 32'd1);
        frames(30); chk("tw_f30", 32'(twinkle), 32'd0);
        frames(30); chk("tw_f60", 32'(twinkle), 32'd1);
        frames(30); chk("tw_f90", 32'(twinkle), 32'd0);
        frames(10);
        chk("held_tap_no_exit", 32'(scene), 32'd5);
        tap = 1'b0; step();
        tap = 1'b1; step();
        chk("repress_exit", 32'(scene), 32'd1);
        chk("repress_twinkle", 32'(twinkle), 32'd0);
        tap = 1'b0; step();

        // Randomised traffic including occasional mid-run reset
        repeat (3000) begin
            frame_tick      = ($urandom % 3) == 0;
            if (($urandom % 12) == 0) tap = ~tap;
            level_sel_valid = ($urandom % 10) == 0;
            level_sel       = 2'($urandom);
            win_evt         = ($urandom % 15) == 0;
            lose_evt        = ($urandom % 17) == 0;
            rst             = ($urandom % 400) != 0;
            step();
        end
        frame_tick = 1'b0; tap = 1'b0; level_sel_valid = 1'b0;
        win_evt = 1'b0; lose_evt = 1'b0; rst = 1'b1;
        step();

        // Mid-operation reset
        rst = 1'b0; step();
        chk("midrst_scene", 32'(scene), 32'd0);
        chk("midrst_twinkle", 32'(twinkle), 32'd1);
        rst = 1'b1;

        // LOSE idle for 600 frames
        frames(20);
        pulse_tap();
        select_level(2'd1);
        chk("menu_to_play2", 32'(scene), 32'd3);
        lose_evt = 1'b1; step(); lose_evt = 1'b0;
        chk("play_to_lose", 32'(scene), 32'd6);
        frames(600);
        cycles(2);
        chk("auto_return", 32'(scene), c_AUTO ? 32'd1 : 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
